uart_rx2: RTL
=============

UART_RX2 -- requirements
Module: uart_rx2

Interface
REQ-001 SHALL have parameter F_CLK, default 12_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter UART_BAUD, default 9600, meaning line bit rate.
REQ-003 SHALL have parameter CLKS_PER_BIT, default F_CLK/UART_BAUD (integer division), meaning clocks per bit period; legal range >= 4.
REQ-004 SHALL have port CLK  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port RX_DATA  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-007 SHALL have port RX_DV  output  1  one-cycle pulse: new valid byte on RX_BYTE.
REQ-008 SHALL have port RX_BYTE  output  8  last correctly framed byte, held until the next valid byte.
REQ-009 SHALL have port RX_ERR  output  1  one-cycle pulse: framing error, stop bit sampled low.
REQ-010 SHALL have port BUSY  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass RX_DATA through a 2-flop synchronizer; all FSM decisions SHALL use the second flop ("rx_s").
REQ-012 SHALL implement states IDLE, START, DATA, STOP, CLEANUP with a bit-period counter and 3-bit bit index.
REQ-013 IDLE: counter and index held at 0; rx_s == 0 -> START.
REQ-014 START: count to HALF = (CLKS_PER_BIT-1)/2; at HALF, rx_s == 0 -> DATA with counter 0; rx_s == 1 -> IDLE (glitch reject, no output pulse).
REQ-015 DATA: count to CLKS_PER_BIT-1; on that cycle SHALL sample rx_s into shift-register bit [index], reset counter, and increment index; after index 7 -> STOP with index 0.
REQ-016 STOP: count to CLKS_PER_BIT-1; on that cycle, rx_s == 1 -> load RX_BYTE from shift register and pulse RX_DV next cycle; rx_s == 0 -> pulse RX_ERR next cycle, RX_BYTE unchanged; either case -> CLEANUP.
REQ-017 CLEANUP: RX_DV/RX_ERR high for exactly this one cycle; rx_s == 1 -> IDLE; rx_s == 0 (break/stuck line) -> stay, outputs low after the first cycle, no new frame until line seen high.
REQ-018 RX_DV and RX_ERR SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-019 Samples SHALL fall within one clock of bit centre: data bit n sampled HALF + (n+1)*CLKS_PER_BIT clocks after START entry.
REQ-020 Back-to-back frames (next start bit right after one stop bit) SHALL be received without loss.
REQ-021 Undefined state encodings SHALL return to IDLE on the next clock.
REQ-022 Counter width SHALL hold CLKS_PER_BIT-1 without wrap; comparisons unsigned.

Reset
REQ-023 While RST is high at a clock edge: state IDLE, counter 0, index 0, shift register 0, RX_BYTE 8'h00, RX_DV 0, RX_ERR 0, BUSY 0, both synchronizer flops 1.
REQ-024 RST mid-frame SHALL abort the frame with no RX_DV/RX_ERR pulse; reception resumes at the next falling edge after release.
REQ-025 RST SHALL take priority over all other logic in the same cycle.

Verification (bench config F_CLK=16, UART_BAUD=1 -> CLKS_PER_BIT=16)
REQ-026 Frame 0xA5, stop high -> one RX_DV pulse, RX_BYTE=8'hA5, RX_ERR=0, BUSY low again after line idle.
REQ-027 RX_DATA low for 5 clocks then high -> no RX_DV/RX_ERR, BUSY high then back to IDLE by clock 10.
REQ-028 After valid 0x12, frame 0x3C with stop bit low -> one RX_ERR pulse, no RX_DV, RX_BYTE stays 8'h12; line held low 100 clocks -> no further pulses; line high then frame 0x55 -> RX_DV, RX_BYTE=8'h55.
REQ-029 Back-to-back frames 0x00, 0xFF, 0x81 with one stop bit each -> three RX_DV pulses in order with matching RX_BYTE, no RX_ERR.
REQ-030 RST asserted one clock during bit 3 of frame 0x77 -> no pulse, RX_BYTE=8'h00; next frame 0x42 -> RX_DV, RX_BYTE=8'h42.
REQ-031 Frame 0xC3 sent at +/-3% baud skew -> RX_DV, RX_BYTE=8'hC3.

Source files
------------

// File: rtl/uart_rx2.sv
// uart_rx2: 8N1 UART receiver. Two-flop input synchronizer, mid-bit sampling,
// one-cycle RX_DV / RX_ERR pulses and break (stuck-low line) handling.
module uart_rx2 #(
  parameter int unsigned F_CLK        = 12_000_000,
  parameter int unsigned UART_BAUD    = 9600,
  parameter int unsigned CLKS_PER_BIT = F_CLK / UART_BAUD
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_DATA,
  output logic       RX_DV,
  output logic [7:0] RX_BYTE,
  output logic       RX_ERR,
  output logic       BUSY
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BitMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfMax = CntW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StCleanup
  } state_e;

  state_e          state_q, state_d;
  logic            sync_q;
  logic            rx_s_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            dv_q, dv_d;
  logic            err_q, err_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      sync_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= RX_DATA;
      rx_s_q  <= sync_q;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (cnt_q == HalfMax) begin
          cnt_d   = '0;
          state_d = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitMax) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == BitMax) begin
          cnt_d   = '0;
          state_d = StCleanup;
          if (rx_s_q) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCleanup: begin
        // Hold here on a break until the line is seen idle again.
        if (rx_s_q) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    BUSY    = (state_q != StIdle);
    RX_DV   = dv_q;
    RX_ERR  = err_q;
    RX_BYTE = byte_q;
  end

endmodule
